// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder: host-side responder for CCI-P line read/write requests.
// Reads return line data after READ_LATENCY stages; writes commit to a local
// line memory and are acknowledged. Both share one response channel through
// per-class FIFOs and an alternating arbiter.
// Optional feature: define CCIP_RESPONDER_STATS_EN to enable rd_count/wr_count.
module ccip_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 42,
  parameter int unsigned MEM_LINES_LOG2  = 6,
  parameter int unsigned MDATA_WIDTH     = 16,
  parameter int unsigned READ_LATENCY    = 4,
  parameter int unsigned RD_FIFO_DEPTH   = 8,
  parameter int unsigned WACK_FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   c0_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c0_req_addr,
  input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
  output logic                   c0_almfull,
  input  logic                   c1_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c1_req_addr,
  input  logic [511:0]           c1_req_data,
  input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
  output logic                   c1_almfull,
  output logic                   rsp_valid,
  output logic                   rsp_is_write,
  output logic [MDATA_WIDTH-1:0] rsp_mdata,
  output logic [511:0]           rsp_data,
  output logic                   err_oob,
  output logic                   err_ovf,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);
  localparam int unsigned MemLines = 2 ** MEM_LINES_LOG2;
  localparam int unsigned RdPtrW   = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned WaPtrW   = $clog2(WACK_FIFO_DEPTH);

  typedef logic [511:0]              line_t;
  typedef logic [MDATA_WIDTH-1:0]    mdata_t;
  typedef logic [MEM_LINES_LOG2-1:0] idx_t;

  // Request decode
  logic c0_in_range, c1_in_range;
  idx_t c0_idx, c1_idx;
  assign c0_in_range = (c0_req_addr >> MEM_LINES_LOG2) == '0;
  assign c1_in_range = (c1_req_addr >> MEM_LINES_LOG2) == '0;
  assign c0_idx      = c0_req_addr[MEM_LINES_LOG2-1:0];
  assign c1_idx      = c1_req_addr[MEM_LINES_LOG2-1:0];

  // Line memory
  line_t mem_q [MemLines];
  logic  mem_we;
  assign mem_we = reset_n && c1_req_valid && c1_in_range;

  // Commit writes; memory is never reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[c1_idx] <= c1_req_data;
  end

  // Read sample: write-first bypass, zero for out-of-range lines.
  line_t rd_line;
  always_comb begin
    rd_line = '0;
    if (c0_in_range) begin
      if (c1_req_valid && c1_in_range && (c1_idx == c0_idx)) rd_line = c1_req_data;
      else                                                   rd_line = mem_q[c0_idx];
    end
  end

  // Read pipeline
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  line_t                   pipe_data_q [READ_LATENCY];
  line_t                   pipe_data_d [READ_LATENCY];
  mdata_t                  pipe_md_q   [READ_LATENCY];
  mdata_t                  pipe_md_d   [READ_LATENCY];
  logic [31:0]             in_flight_d;

  // Shift the read pipeline by one stage and count reads still in it.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = c0_req_valid;
    pipe_data_d[0] = rd_line;
    pipe_md_d[0]   = c0_req_mdata;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
      pipe_md_d[i]   = pipe_md_q[i-1];
    end
    in_flight_d = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight_d = in_flight_d + 32'(pipe_vld_d[i]);
  end

  // Read-response FIFO
  line_t               rdf_data_q [RD_FIFO_DEPTH];
  mdata_t              rdf_md_q   [RD_FIFO_DEPTH];
  logic [RdPtrW-1:0]   rdf_wptr_q, rdf_wptr_d, rdf_rptr_q, rdf_rptr_d;
  logic [RdPtrW:0]     rdf_cnt_q, rdf_cnt_d;
  logic                rdf_full, rdf_push, rdf_drop, rdf_pop;

  // Write-ack FIFO
  mdata_t              waf_md_q [WACK_FIFO_DEPTH];
  logic [WaPtrW-1:0]   waf_wptr_q, waf_wptr_d, waf_rptr_q, waf_rptr_d;
  logic [WaPtrW:0]     waf_cnt_q, waf_cnt_d;
  logic                waf_full, waf_push, waf_drop, waf_pop;

  // Arbiter and flags
  logic last_wr_q, last_wr_d;
  logic err_oob_q, err_oob_d, err_ovf_q, err_ovf_d;
  logic c0_almfull_q, c0_almfull_d, c1_almfull_q, c1_almfull_d;

  // Arrivals at a full FIFO are dropped even if the same cycle pops.
  assign rdf_full = 32'(rdf_cnt_q) == RD_FIFO_DEPTH;
  assign rdf_push = pipe_vld_q[READ_LATENCY-1] && !rdf_full;
  assign rdf_drop = pipe_vld_q[READ_LATENCY-1] && rdf_full;
  assign waf_full = 32'(waf_cnt_q) == WACK_FIFO_DEPTH;
  assign waf_push = c1_req_valid && !waf_full;
  assign waf_drop = c1_req_valid && waf_full;

  // Alternating arbiter; responses come straight from the FIFO heads.
  always_comb begin
    rdf_pop = (rdf_cnt_q != '0) && ((waf_cnt_q == '0) || last_wr_q);
    waf_pop = (waf_cnt_q != '0) && !rdf_pop;
    last_wr_d = last_wr_q;
    if (rdf_pop)      last_wr_d = 1'b0;
    else if (waf_pop) last_wr_d = 1'b1;
    rsp_valid    = rdf_pop || waf_pop;
    rsp_is_write = waf_pop;
    rsp_mdata    = '0;
    rsp_data     = '0;
    if (rdf_pop) begin
      rsp_mdata = rdf_md_q[rdf_rptr_q];
      rsp_data  = rdf_data_q[rdf_rptr_q];
    end else if (waf_pop) begin
      rsp_mdata = waf_md_q[waf_rptr_q];
    end
  end

  // FIFO bookkeeping, sticky errors and almost-full thresholds.
  always_comb begin
    rdf_wptr_d   = rdf_wptr_q + RdPtrW'(rdf_push);
    rdf_rptr_d   = rdf_rptr_q + RdPtrW'(rdf_pop);
    rdf_cnt_d    = rdf_cnt_q + (RdPtrW + 1)'(rdf_push) - (RdPtrW + 1)'(rdf_pop);
    waf_wptr_d   = waf_wptr_q + WaPtrW'(waf_push);
    waf_rptr_d   = waf_rptr_q + WaPtrW'(waf_pop);
    waf_cnt_d    = waf_cnt_q + (WaPtrW + 1)'(waf_push) - (WaPtrW + 1)'(waf_pop);
    err_oob_d    = err_oob_q || (c0_req_valid && !c0_in_range) ||
                   (c1_req_valid && !c1_in_range);
    err_ovf_d    = err_ovf_q || rdf_drop || waf_drop;
    // Thresholds use next-state occupancy so the flag tracks the current fill.
    c0_almfull_d = (32'(rdf_cnt_d) + in_flight_d) >= (RD_FIFO_DEPTH - 2);
    c1_almfull_d = 32'(waf_cnt_d) >= (WACK_FIFO_DEPTH - 2);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_vld_q   <= '0;
      rdf_wptr_q   <= '0;
      rdf_rptr_q   <= '0;
      rdf_cnt_q    <= '0;
      waf_wptr_q   <= '0;
      waf_rptr_q   <= '0;
      waf_cnt_q    <= '0;
      last_wr_q    <= 1'b1;
      err_oob_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      c0_almfull_q <= 1'b0;
      c1_almfull_q <= 1'b0;
    end else begin
      pipe_vld_q   <= pipe_vld_d;
      rdf_wptr_q   <= rdf_wptr_d;
      rdf_rptr_q   <= rdf_rptr_d;
      rdf_cnt_q    <= rdf_cnt_d;
      waf_wptr_q   <= waf_wptr_d;
      waf_rptr_q   <= waf_rptr_d;
      waf_cnt_q    <= waf_cnt_d;
      last_wr_q    <= last_wr_d;
      err_oob_q    <= err_oob_d;
      err_ovf_q    <= err_ovf_d;
      c0_almfull_q <= c0_almfull_d;
      c1_almfull_q <= c1_almfull_d;
    end
  end

  // Payload storage; qualified by the valids and pointers above.
  always_ff @(posedge clk) begin
    pipe_data_q <= pipe_data_d;
    pipe_md_q   <= pipe_md_d;
    if (rdf_push) begin
      rdf_data_q[rdf_wptr_q] <= pipe_data_q[READ_LATENCY-1];
      rdf_md_q[rdf_wptr_q]   <= pipe_md_q[READ_LATENCY-1];
    end
    if (waf_push) waf_md_q[waf_wptr_q] <= c1_req_mdata;
  end

  assign err_oob    = err_oob_q;
  assign err_ovf    = err_ovf_q;
  assign c0_almfull = c0_almfull_q;
  assign c1_almfull = c1_almfull_q;

`ifdef CCIP_RESPONDER_STATS_EN
  logic [31:0] rd_stat_q, rd_stat_d, wr_stat_q, wr_stat_d;

  // Accepted-request counters; wrap silently.
  always_comb begin
    rd_stat_d = rd_stat_q + 32'(c0_req_valid);
    wr_stat_d = wr_stat_q + 32'(c1_req_valid);
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_stat_q <= '0;
      wr_stat_q <= '0;
    end else begin
      rd_stat_q <= rd_stat_d;
      wr_stat_q <= wr_stat_d;
    end
  end

  assign rd_count = rd_stat_q;
  assign wr_count = wr_stat_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: doc/ccip_mem_responder.md
# ccip_mem_responder

Host-memory responder for the CCI-P line-addressed request interface: it plays the host side against an AFU that issues cache-line read and write requests. Reads return line data after a fixed pipeline latency; writes commit to a local line memory and are acknowledged. Read data and write acks share one response channel through per-class FIFOs and an alternating arbiter. It backs multiplier/divider AFU benches in simulation and stands in for host memory in stand-alone emulation builds.

## Interface
- ADDR_WIDTH, 42: cache-line address width (byte address >> 6)
- MEM_LINES_LOG2, 6: log2 of line-memory depth (64 lines)
- MDATA_WIDTH, 16: request tag width, echoed in responses
- READ_LATENCY, 4: read pipeline stages, legal 1..16
- RD_FIFO_DEPTH, 8: read-response FIFO entries (power of 2, >=4)
- WACK_FIFO_DEPTH, 8: write-ack FIFO entries (power of 2, >=4)

- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- c0_req_valid  in  1  read request strobe
- c0_req_addr  in  ADDR_WIDTH  read line address
- c0_req_mdata  in  MDATA_WIDTH  read tag
- c0_almfull  out  1  read requests must stop
- c1_req_valid  in  1  write request strobe
- c1_req_addr  in  ADDR_WIDTH  write line address
- c1_req_data  in  512  write line data
- c1_req_mdata  in  MDATA_WIDTH  write tag
- c1_almfull  out  1  write requests must stop
- rsp_valid  out  1  response strobe (no backpressure)
- rsp_is_write  out  1  1 = write ack, 0 = read data
- rsp_mdata  out  MDATA_WIDTH  echoed tag
- rsp_data  out  512  read data; zero for write acks
- err_oob  out  1  sticky: out-of-range address seen
- err_ovf  out  1  sticky: request dropped because its FIFO was full
- rd_count  out  32  accepted reads (stats)
- wr_count  out  32  accepted writes (stats)

## Operation
- Reads and writes may be presented in the same cycle; both are accepted.
- Write: in the request cycle, line written at addr[MEM_LINES_LOG2-1:0]; ack {mdata} pushed to the write-ack FIFO at the same edge.
- Read: memory sampled in the request cycle, write-first: same-cycle, same-address write → read returns the new data. Data + mdata traverse READ_LATENCY stages, then push to the read FIFO.
- Out of range (any addr bit at or above MEM_LINES_LOG2 set): read returns all zeros; write does not modify memory but is still acked; err_oob set.
- Arbiter: at most one response per cycle. One FIFO non-empty → that FIFO pops. Both non-empty → grant the class not granted last. After reset, last-granted = write, so reads win the first contention.
- c0_almfull = (rd FIFO occupancy + reads in flight) >= RD_FIFO_DEPTH-2, registered.
- c1_almfull = wack occupancy >= WACK_FIFO_DEPTH-2, registered.
- Overflow: an arrival at a full FIFO is dropped, err_ovf set, and occupancy is unchanged. This applies to a read leaving the pipeline or to a write ack. For a dropped write ack, the memory write still commits.
- Responses carry per-class order; no ordering between reads and writes.

## Timing
- Reset (reset_n=0 at a clk edge): rsp_valid, rsp_is_write, rsp_mdata, rsp_data, c0_almfull, c1_almfull, err_oob, err_ovf, rd_count, wr_count all 0.
- Reset also empties both FIFOs and invalidates all pipeline stages. Memory contents are not reset.
- Reset mid-operation: in-flight reads and queued acks are discarded; no response appears for pre-reset requests. Memory writes committed before reset persist.
- Read request in cycle T → rsp_valid earliest in cycle T+READ_LATENCY+1.
- Write request in cycle T → ack earliest in cycle T+1.
- Requests in the cycle c*_almfull rises are accepted; the requester keeps at least 2 entries of slack.
- Counters wrap at 2^32 silently.

## Configuration
- CCIP_RESPONDER_STATS_EN defined: rd_count/wr_count increment once per accepted request. Out-of-range requests count; a write whose ack is dropped still counts.
- Not defined: counters absent; rd_count and wr_count tied to 0.

## Test plan
- Write line 5 = 0xA5..A5 with mdata 0x11 at T, read line 5 with mdata 0x22 at T+3 → write ack (is_write=1, mdata 0x11) at T+1; read data 0xA5..A5, mdata 0x22, at T+8 (READ_LATENCY=4).
- Same-cycle write line 3 = 0x1234 and read line 3 → read returns 0x1234 (write-first); one ack and one read response, read granted first on contention.
- Eight back-to-back writes plus overlapping reads → responses alternate read/write while both FIFOs are non-empty; per-class mdata order is preserved.
- Read line 64 with MEM_LINES_LOG2=6 → read returns zero data, err_oob=1. A later write to line 64 is acked and memory is unchanged.
- Ten writes per cycle with almfull ignored, while reads saturate the arbiter → c1_almfull rises at occupancy 6. Excess acks are dropped, err_ovf=1, and memory still holds all ten lines.
- Reset pulse while 3 reads are in flight → no rsp_valid afterwards, and both almfull and error flags are 0. A re-read returns the pre-reset written data; rd_count=0 after reset (stats build).
